// File: rtl/usb_pkt_rx.sv
// usb_pkt_rx: decodes USB packets from the ULPI receive byte stream.
// Ports:
//   CLK_60M, NRST_A_USB            - 60 MHz ULPI clock, async active-low reset
//   USB_DATA_OUT[7:0], *_STRB       - received byte and its one-cycle valid
//   USB_DATA_OUT_END / _FAIL        - one-cycle packet-end / receive-abort pulses
//   PID, TOKEN_ADDR, TOKEN_ENDP     - decoded packet identifier and token fields
//   PAYLOAD, PAYLOAD_STRB           - DATA payload bytes (CRC bytes stripped)
//   PKT_DONE, PKT_ERR, ERR_CODE     - packet-closed pulse with error qualifier/code
module usb_pkt_rx #(
    parameter int unsigned MAX_PAYLOAD = 1024
) (
    input  logic       CLK_60M,
    input  logic       NRST_A_USB,
    input  logic [7:0] USB_DATA_OUT,
    input  logic       USB_DATA_OUT_STRB,
    input  logic       USB_DATA_OUT_END,
    input  logic       USB_DATA_OUT_FAIL,
    output logic [3:0] PID,
    output logic [6:0] TOKEN_ADDR,
    output logic [3:0] TOKEN_ENDP,
    output logic [7:0] PAYLOAD,
    output logic       PAYLOAD_STRB,
    output logic       PKT_DONE,
    output logic       PKT_ERR,
    output logic [2:0] ERR_CODE
);

    localparam int unsigned CNT_W = 16;
    // A byte at count N releases payload byte N-2; N-1 payload bytes have then been emitted.
    localparam logic [CNT_W:0] EMIT_LIMIT = (CNT_W + 1)'(MAX_PAYLOAD + 1);

    localparam logic [2:0]  ERR_NONE   = 3'd0;
    localparam logic [2:0]  ERR_PID    = 3'd1;
    localparam logic [2:0]  ERR_CRC    = 3'd2;
    localparam logic [2:0]  ERR_LEN    = 3'd3;
    localparam logic [2:0]  ERR_ABORT  = 3'd4;
    localparam logic [4:0]  CRC5_INIT  = 5'h1F;
    localparam logic [4:0]  CRC5_GOOD  = 5'h0C;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam logic [15:0] CRC16_GOOD = 16'h800D;

    typedef enum logic [2:0] {IDLE, TOKEN, DATA, HSK, DRAIN} state_t;

    // Serial CRCs, one byte per call, LSB of the byte first.
    function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] b);
        logic [4:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[4] ^ b[i]) ? ({c[3:0], 1'b0} ^ 5'h05) : {c[3:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[15] ^ b[i]) ? ({c[14:0], 1'b0} ^ 16'h8005) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         crc5_q, crc5_d;
    logic [15:0]        crc16_q, crc16_d;
    logic [7:0]         d0_q, d0_d, d1_q, d1_d;
    logic [2:0]         err_q, err_d;
    logic [3:0]         pid_d;
    logic [6:0]         addr_d;
    logic [3:0]         endp_d;
    logic [7:0]         payload_d;
    logic               payload_strb_d, pkt_done_d, pkt_err_d;
    logic [2:0]         err_code_d;
    logic               fin;
    logic [2:0]         fin_code;

    // State and output registers.
    always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
        if (!NRST_A_USB) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            crc5_q       <= '0;
            crc16_q      <= '0;
            d0_q         <= '0;
            d1_q         <= '0;
            err_q        <= ERR_NONE;
            PID          <= '0;
            TOKEN_ADDR   <= '0;
            TOKEN_ENDP   <= '0;
            PAYLOAD      <= '0;
            PAYLOAD_STRB <= 1'b0;
            PKT_DONE     <= 1'b0;
            PKT_ERR      <= 1'b0;
            ERR_CODE     <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            crc5_q       <= crc5_d;
            crc16_q      <= crc16_d;
            d0_q         <= d0_d;
            d1_q         <= d1_d;
            err_q        <= err_d;
            PID          <= pid_d;
            TOKEN_ADDR   <= addr_d;
            TOKEN_ENDP   <= endp_d;
            PAYLOAD      <= payload_d;
            PAYLOAD_STRB <= payload_strb_d;
            PKT_DONE     <= pkt_done_d;
            PKT_ERR      <= pkt_err_d;
            ERR_CODE     <= err_code_d;
        end
    end

    // Next-state and output decode. The *_d values already include a byte
    // strobed this cycle, so a simultaneous END is judged with that byte counted.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        crc5_d         = crc5_q;
        crc16_d        = crc16_q;
        d0_d           = d0_q;
        d1_d           = d1_q;
        err_d          = err_q;
        pid_d          = PID;
        addr_d         = TOKEN_ADDR;
        endp_d         = TOKEN_ENDP;
        payload_d      = PAYLOAD;
        payload_strb_d = 1'b0;
        pkt_done_d     = 1'b0;
        pkt_err_d      = 1'b0;
        err_code_d     = ERR_CODE;
        fin            = 1'b0;
        fin_code       = ERR_NONE;

        case (state_q)
            IDLE: begin
                if (!USB_DATA_OUT_FAIL) begin
                    if (USB_DATA_OUT_STRB) begin
                        pid_d   = USB_DATA_OUT[3:0];
                        cnt_d   = '0;
                        crc5_d  = CRC5_INIT;
                        crc16_d = CRC16_INIT;
                        d0_d    = '0;
                        d1_d    = '0;
                        if ((USB_DATA_OUT[7:4] != ~USB_DATA_OUT[3:0]) || (USB_DATA_OUT[1:0] == 2'b00)) begin
                            state_d = DRAIN;
                            err_d   = ERR_PID;
                            if (USB_DATA_OUT_END) begin
                                fin      = 1'b1;
                                fin_code = ERR_PID;
                            end
                        end else if (USB_DATA_OUT[1:0] == 2'b10) begin
                            state_d = HSK;
                            if (USB_DATA_OUT_END) begin
                                fin      = 1'b1;
                                fin_code = ERR_NONE;
                            end
                        end else begin
                            state_d = USB_DATA_OUT[1] ? DATA : TOKEN;
                            if (USB_DATA_OUT_END) begin
                                fin      = 1'b1;
                                fin_code = ERR_LEN;
                            end
                        end
                    end else if (USB_DATA_OUT_END) begin
                        fin      = 1'b1;
                        fin_code = ERR_LEN;
                    end
                end
            end

            TOKEN: begin
                if (USB_DATA_OUT_FAIL) begin
                    fin      = 1'b1;
                    fin_code = ERR_ABORT;
                end else if (USB_DATA_OUT_STRB && (cnt_q == CNT_W'(2))) begin
                    state_d = DRAIN;
                    err_d   = ERR_LEN;
                    if (USB_DATA_OUT_END) begin
                        fin      = 1'b1;
                        fin_code = ERR_LEN;
                    end
                end else begin
                    if (USB_DATA_OUT_STRB) begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        crc5_d = crc5_byte(crc5_q, USB_DATA_OUT);
                        d1_d   = d0_q;
                        d0_d   = USB_DATA_OUT;
                    end
                    if (USB_DATA_OUT_END) begin
                        fin = 1'b1;
                        if (cnt_d != CNT_W'(2)) begin
                            fin_code = ERR_LEN;
                        end else if (crc5_d != CRC5_GOOD) begin
                            fin_code = ERR_CRC;
                        end else begin
                            fin_code = ERR_NONE;
                            addr_d   = d1_d[6:0];
                            endp_d   = {d0_d[2:0], d1_d[7]};
                        end
                    end
                end
            end

            DATA: begin
                if (USB_DATA_OUT_FAIL) begin
                    fin      = 1'b1;
                    fin_code = ERR_ABORT;
                end else begin
                    if (USB_DATA_OUT_STRB) begin
                        // Oldest held byte is now known not to be CRC: release it.
                        if (cnt_q >= CNT_W'(2)) begin
                            if ({1'b0, cnt_q} > EMIT_LIMIT) begin
                                state_d = DRAIN;
                                err_d   = ERR_LEN;
                            end else begin
                                payload_d      = d1_q;
                                payload_strb_d = 1'b1;
                            end
                        end
                        cnt_d   = cnt_q + CNT_W'(1);
                        crc16_d = crc16_byte(crc16_q, USB_DATA_OUT);
                        d1_d    = d0_q;
                        d0_d    = USB_DATA_OUT;
                    end
                    if (USB_DATA_OUT_END) begin
                        fin = 1'b1;
                        if ((state_d == DRAIN) || (cnt_d < CNT_W'(2))) begin
                            fin_code = ERR_LEN;
                        end else if (crc16_d != CRC16_GOOD) begin
                            fin_code = ERR_CRC;
                        end else begin
                            fin_code = ERR_NONE;
                        end
                    end
                end
            end

            HSK: begin
                if (USB_DATA_OUT_FAIL) begin
                    fin      = 1'b1;
                    fin_code = ERR_ABORT;
                end else if (USB_DATA_OUT_STRB) begin
                    state_d = DRAIN;
                    err_d   = ERR_LEN;
                    if (USB_DATA_OUT_END) begin
                        fin      = 1'b1;
                        fin_code = ERR_LEN;
                    end
                end else if (USB_DATA_OUT_END) begin
                    fin      = 1'b1;
                    fin_code = ERR_NONE;
                end
            end

            DRAIN: begin
                if (USB_DATA_OUT_FAIL) begin
                    fin      = 1'b1;
                    fin_code = ERR_ABORT;
                end else if (USB_DATA_OUT_END) begin
                    fin      = 1'b1;
                    fin_code = err_q;
                end
            end

            default: state_d = IDLE;
        endcase

        // Close the packet: report, flush the pipeline, return to IDLE.
        if (fin) begin
            state_d    = IDLE;
            pkt_done_d = 1'b1;
            pkt_err_d  = (fin_code != ERR_NONE);
            err_code_d = fin_code;
            cnt_d      = '0;
            crc5_d     = '0;
            crc16_d    = '0;
            d0_d       = '0;
            d1_d       = '0;
            err_d      = ERR_NONE;
        end
    end

endmodule

// File: tb/tb_usb_pkt_rx.sv
// tb_usb_pkt_rx: directed bench for usb_pkt_rx (default and MAX_PAYLOAD=4 instances).
module tb_usb_pkt_rx;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic       strb, pend, pfail;

    logic [3:0] pid_a, endp_a, pid_b, endp_b;
    logic [6:0] addr_a, addr_b;
    logic [7:0] pay_a, pay_b;
    logic       pstrb_a, done_a, perr_a, pstrb_b, done_b, perr_b;
    logic [2:0] code_a, code_b;

    usb_pkt_rx dut_a (
        .CLK_60M(clk), .NRST_A_USB(rst_n),
        .USB_DATA_OUT(data), .USB_DATA_OUT_STRB(strb),
        .USB_DATA_OUT_END(pend), .USB_DATA_OUT_FAIL(pfail),
        .PID(pid_a), .TOKEN_ADDR(addr_a), .TOKEN_ENDP(endp_a),
        .PAYLOAD(pay_a), .PAYLOAD_STRB(pstrb_a),
        .PKT_DONE(done_a), .PKT_ERR(perr_a), .ERR_CODE(code_a)
    );

    usb_pkt_rx #(.MAX_PAYLOAD(4)) dut_b (
        .CLK_60M(clk), .NRST_A_USB(rst_n),
        .USB_DATA_OUT(data), .USB_DATA_OUT_STRB(strb),
        .USB_DATA_OUT_END(pend), .USB_DATA_OUT_FAIL(pfail),
        .PID(pid_b), .TOKEN_ADDR(addr_b), .TOKEN_ENDP(endp_b),
        .PAYLOAD(pay_b), .PAYLOAD_STRB(pstrb_b),
        .PKT_DONE(done_b), .PKT_ERR(perr_b), .ERR_CODE(code_b)
    );

    always #8 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pstrb_cnt_a = 0;
    int pstrb_cnt_b = 0;
    int done_cnt_a = 0;
    logic [7:0] pay_log[$];

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (pstrb_a) begin
            pstrb_cnt_a++;
            pay_log.push_back(pay_a);
        end
        if (pstrb_b) pstrb_cnt_b++;
        if (done_a) done_cnt_a++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] b, input logic s, input logic e, input logic f);
        @(negedge clk);
        data  = b;
        strb  = s;
        pend  = e;
        pfail = f;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            data  = '0;
            strb  = 1'b0;
            pend  = 1'b0;
            pfail = 1'b0;
        end
        #1;
    endtask

    // Bytes back to back, then a separate END cycle; leaves time at the PKT_DONE cycle.
    task automatic send_pkt(input bq_t q);
        foreach (q[i]) drive(q[i], 1'b1, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        quiet(1);
    endtask

    // Token bytes {b2, b1} generated transmitter-style: CRC5 over 11 bits, inverted, MSB first.
    function automatic logic [15:0] tok(input logic [6:0] a, input logic [3:0] e);
        logic [10:0] d;
        logic [4:0]  c;
        logic [7:0]  b2;
        d = {e, a};
        c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            c = (c[4] ^ d[i]) ? ({c[3:0], 1'b0} ^ 5'h05) : {c[3:0], 1'b0};
        end
        c  = ~c;
        b2 = {c[0], c[1], c[2], c[3], c[4], e[3:1]};
        return {b2, e[0], a};
    endfunction

    initial begin
        bq_t         pkt;
        logic [15:0] t;
        logic [7:0]  exp_pay[8];
        int          dc;

        exp_pay = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
        rst_n = 1'b1;
        data  = '0;
        strb  = 1'b0;
        pend  = 1'b0;
        pfail = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pid", pid_a, 4'h0);
        chk("rst_addr_endp", {addr_a, endp_a}, 11'h0);
        chk("rst_outs", {pstrb_a, done_a, perr_a, code_a}, 6'h0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet(2);

        // SETUP token addr 0 endp 0
        pkt = '{8'h2D, 8'h00, 8'h10};
        send_pkt(pkt);
        chk("tok0_done", {done_a, perr_a, code_a}, 5'b10_000);
        chk("tok0_pid", pid_a, 4'hD);
        chk("tok0_addr_endp", {addr_a, endp_a}, 11'h0);
        quiet(1);
        chk("tok0_pulse", done_a, 1'b0);

        // IN token addr 3A endp A
        t = tok(7'h3A, 4'hA);
        pkt = '{8'h69, t[7:0], t[15:8]};
        send_pkt(pkt);
        chk("tok3a_done", {done_a, perr_a, code_a}, 5'b10_000);
        chk("tok3a_addr", addr_a, 7'h3A);
        chk("tok3a_endp", endp_a, 4'hA);

        // Corrupted token CRC: code 2, fields untouched
        pkt = '{8'h2D, 8'h00, 8'h11};
        send_pkt(pkt);
        chk("tokcrc_done", {done_a, perr_a, code_a}, 5'b11_010);
        chk("tokcrc_keep", {addr_a, endp_a}, {7'h3A, 4'hA});

        // Good DATA0 with explicit pipeline timing
        quiet(1);
        pay_log.delete();
        pstrb_cnt_a = 0;
        drive(8'hC3, 1'b1, 1'b0, 1'b0);
        drive(8'h80, 1'b1, 1'b0, 1'b0);
        drive(8'h06, 1'b1, 1'b0, 1'b0);
        drive(8'h00, 1'b1, 1'b0, 1'b0);
        #1 chk("data_lat_early", pstrb_a, 1'b0);
        drive(8'h01, 1'b1, 1'b0, 1'b0);
        #1 chk("data_lat_first", {pstrb_a, pay_a}, 9'h180);
        pkt = '{8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
        send_pkt(pkt);
        chk("data_done", {done_a, perr_a, code_a}, 5'b10_000);
        chk("data_pid", pid_a, 4'h3);
        quiet(2);
        chk("data_nstrb", pstrb_cnt_a, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("data_byte%0d", i), pay_log[i], exp_pay[i]);

        // Same DATA0 with bad last CRC byte
        pkt = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h95};
        send_pkt(pkt);
        chk("datacrc_done", {done_a, perr_a, code_a}, 5'b11_010);

        // Handshake ACK
        pkt = '{8'hD2};
        send_pkt(pkt);
        chk("ack_done", {done_a, perr_a, code_a}, 5'b10_000);
        chk("ack_pid", pid_a, 4'h2);

        // Bad PID check
        quiet(1);
        pstrb_cnt_a = 0;
        pkt = '{8'h2E};
        send_pkt(pkt);
        chk("badpid_done", {done_a, perr_a, code_a}, 5'b11_001);
        quiet(2);
        chk("badpid_nstrb", pstrb_cnt_a, 0);

        // Abort mid-DATA, then a clean packet
        pkt = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01};
        foreach (pkt[i]) drive(pkt[i], 1'b1, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        quiet(1);
        chk("abort_done", {done_a, perr_a, code_a}, 5'b11_100);
        pkt = '{8'hD2};
        send_pkt(pkt);
        chk("abort_next", {done_a, perr_a, code_a}, 5'b10_000);

        // Oversize payload on MAX_PAYLOAD=4 instance
        quiet(1);
        pstrb_cnt_b = 0;
        pkt = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40};
        send_pkt(pkt);
        chk("max_done", {done_b, perr_b, code_b}, 5'b11_011);
        quiet(2);
        chk("max_nstrb", pstrb_cnt_b, 4);

        // Zero-length packet
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        quiet(1);
        chk("zlp_done", {done_a, perr_a, code_a}, 5'b11_011);

        // Handshake with an extra byte
        pkt = '{8'hD2, 8'h00};
        send_pkt(pkt);
        chk("hsk_long", {done_a, perr_a, code_a}, 5'b11_011);

        // Token with a third extra byte, and a short token
        pkt = '{8'h2D, 8'h00, 8'h10, 8'h00};
        send_pkt(pkt);
        chk("tok_long", {done_a, perr_a, code_a}, 5'b11_011);
        pkt = '{8'h2D, 8'h00};
        send_pkt(pkt);
        chk("tok_short", {done_a, perr_a, code_a}, 5'b11_011);

        // STRB and END in the same cycle
        drive(8'hD2, 1'b1, 1'b1, 1'b0);
        quiet(1);
        chk("same_hsk", {done_a, perr_a, code_a}, 5'b10_000);
        t = tok(7'h15, 4'h7);
        drive(8'hE1, 1'b1, 1'b0, 1'b0);
        drive(t[7:0], 1'b1, 1'b0, 1'b0);
        drive(t[15:8], 1'b1, 1'b1, 1'b0);
        quiet(1);
        chk("same_tok", {done_a, perr_a, code_a}, 5'b10_000);
        chk("same_tok_fields", {pid_a, addr_a, endp_a}, {4'h1, 7'h15, 4'h7});

        // FAIL in IDLE is ignored and drops a simultaneous byte
        quiet(1);
        dc = done_cnt_a;
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        drive(8'h5A, 1'b1, 1'b0, 1'b1);
        quiet(3);
        chk("idlefail_nodone", done_cnt_a, dc);
        chk("idlefail_pid", pid_a, 4'h1);

        // Reset after the third byte of a DATA packet
        drive(8'hC3, 1'b1, 1'b0, 1'b0);
        drive(8'h80, 1'b1, 1'b0, 1'b0);
        drive(8'h06, 1'b1, 1'b0, 1'b0);
        #3;
        strb  = 1'b0;
        rst_n = 1'b0;
        #1;
        dc = done_cnt_a;
        chk("mrst_pid_addr", {pid_a, addr_a, endp_a}, 15'h0);
        chk("mrst_outs", {pay_a, pstrb_a, done_a, perr_a, code_a}, 14'h0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet(3);
        chk("mrst_nodone", done_cnt_a, dc);
        pkt = '{8'h2D, 8'h00, 8'h10};
        send_pkt(pkt);
        chk("mrst_next", {done_a, perr_a, code_a}, 5'b10_000);
        chk("mrst_next_pid", pid_a, 4'hD);

        quiet(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
